// File: rtl/line_buffer_reg_pkg.sv
// Shared definitions for the line-buffer register file: register byte
// offsets, field positions and widths, reset constants and interrupt bit
// indices. Optional build macro used by the top: LINE_BUFFER_REG_ERR_CNT_EN.
package line_buffer_reg_pkg;

  // Register byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_LINE_CFG = 8'h04;
  localparam logic [7:0] OFF_CMD      = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_INT_RAW  = 8'h10;
  localparam logic [7:0] OFF_INT_EN   = 8'h14;
  localparam logic [7:0] OFF_INT_STAT = 8'h18;
  localparam logic [7:0] OFF_VERSION  = 8'h1C;
  localparam logic [7:0] OFF_ERR_CNT  = 8'h20;

  // CTRL fields
  localparam int unsigned CTRL_W           = 32'd4;
  localparam int unsigned CTRL_LB_EN_BIT   = 32'd0;
  localparam int unsigned CTRL_BYPASS_BIT  = 32'd1;
  localparam int unsigned CTRL_PIX_FMT_LSB = 32'd2;
  localparam int unsigned CTRL_PIX_FMT_MSB = 32'd3;

  // CMD fields
  localparam int unsigned CMD_SOFT_RST_BIT = 32'd0;
  localparam int unsigned CMD_FLUSH_BIT    = 32'd1;

  // Interrupt bit indices shared by INT_RAW / INT_EN / INT_STAT
  localparam int unsigned INT_W          = 32'd3;
  localparam int unsigned INT_FRAME_DONE = 32'd0;
  localparam int unsigned INT_OVERFLOW   = 32'd1;
  localparam int unsigned INT_UNDERFLOW  = 32'd2;

  // Error counter width
  localparam int unsigned ERR_CNT_W = 32'd16;

  // Reset values
  localparam logic [CTRL_W-1:0] CTRL_RST   = 4'h0;
  localparam logic [INT_W-1:0]  INT_EN_RST = 3'h0;

  // Byte offset of a register from the word index carried in addr[7:2]
  function automatic logic [7:0] reg_offset(input logic [5:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/line_buffer_reg_w1c.sv
// One sticky interrupt status bit: set by a hardware event, cleared by a
// write-one-to-clear; when both happen in the same cycle the set wins so
// an event is never lost.
module line_buffer_reg_w1c (
  input  logic pclk,
  input  logic presetn,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Sticky bit with set-over-clear priority
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/line_buffer_reg.sv
// Line-buffer register file behind the APB translation stage. Holds the
// configuration registers, issues one-cycle command pulses, captures core
// events into W1C status bits and drives a masked, registered irq.
// Build option: define LINE_BUFFER_REG_ERR_CNT_EN to add the read-clear
// ERR_CNT register at offset 0x20.
module line_buffer_reg
  import line_buffer_reg_pkg::*;
#(
  parameter logic [31:0]     BASE_ADDR = 32'h0000_0000,
  parameter int unsigned     LW_W      = 32'd13,
  parameter logic [LW_W-1:0] LW_RST    = 13'd1920,
  parameter logic [31:0]     VERSION   = 32'h0001_0000
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            apbif_wr,
  input  logic            apbif_rd,
  input  logic [31:0]     apbif_addr,
  input  logic [31:0]     apbif_wdata,
  output logic [31:0]     apbif_rdata,
  output logic            cfg_lb_en,
  output logic            cfg_bypass,
  output logic [1:0]      cfg_pix_fmt,
  output logic [LW_W-1:0] cfg_line_width,
  output logic            cmd_soft_rst,
  output logic            cmd_flush,
  input  logic            sts_busy,
  input  logic            sts_empty,
  input  logic            sts_full,
  input  logic            evt_frame_done,
  input  logic            evt_overflow,
  input  logic            evt_underflow,
  output logic            irq
);

  logic              hit_s;
  logic [7:0]        offset_s;
  logic              wr_hit_s;
  logic              wr_ctrl_s, wr_line_cfg_s, wr_cmd_s, wr_int_raw_s, wr_int_en_s;
  logic [CTRL_W-1:0] ctrl_r;
  logic [LW_W-1:0]   line_width_r;
  logic [INT_W-1:0]  int_en_r;
  logic [INT_W-1:0]  int_raw_s;
  logic [INT_W-1:0]  evt_s;

  assign hit_s         = (apbif_addr[31:8] == BASE_ADDR[31:8]);
  assign offset_s      = reg_offset(apbif_addr[7:2]);
  assign wr_hit_s      = apbif_wr & hit_s;
  assign wr_ctrl_s     = wr_hit_s & (offset_s == OFF_CTRL);
  assign wr_line_cfg_s = wr_hit_s & (offset_s == OFF_LINE_CFG);
  assign wr_cmd_s      = wr_hit_s & (offset_s == OFF_CMD);
  assign wr_int_raw_s  = wr_hit_s & (offset_s == OFF_INT_RAW);
  assign wr_int_en_s   = wr_hit_s & (offset_s == OFF_INT_EN);

  assign cfg_lb_en      = ctrl_r[CTRL_LB_EN_BIT];
  assign cfg_bypass     = ctrl_r[CTRL_BYPASS_BIT];
  assign cfg_pix_fmt    = ctrl_r[CTRL_PIX_FMT_MSB:CTRL_PIX_FMT_LSB];
  assign cfg_line_width = line_width_r;

  // Read/write configuration registers: CTRL, LINE_CFG and INT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_r       <= CTRL_RST;
      line_width_r <= LW_RST;
      int_en_r     <= INT_EN_RST;
    end else begin
      if (wr_ctrl_s)     ctrl_r       <= apbif_wdata[CTRL_W-1:0];
      if (wr_line_cfg_s) line_width_r <= apbif_wdata[LW_W-1:0];
      if (wr_int_en_s)   int_en_r     <= apbif_wdata[INT_W-1:0];
    end
  end

  // Command pulses: high for exactly the cycle after a CMD write of 1
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cmd_soft_rst <= 1'b0;
      cmd_flush    <= 1'b0;
    end else begin
      cmd_soft_rst <= wr_cmd_s & apbif_wdata[CMD_SOFT_RST_BIT];
      cmd_flush    <= wr_cmd_s & apbif_wdata[CMD_FLUSH_BIT];
    end
  end

  // Map the event inputs onto their interrupt bit positions
  always_comb begin
    evt_s                 = {INT_W{1'b0}};
    evt_s[INT_FRAME_DONE] = evt_frame_done;
    evt_s[INT_OVERFLOW]   = evt_overflow;
    evt_s[INT_UNDERFLOW]  = evt_underflow;
  end

  for (genvar i = 0; i < int'(INT_W); i++) begin : g_int_raw
    line_buffer_reg_w1c u_w1c (
      .pclk    (pclk),
      .presetn (presetn),
      .set     (evt_s[i]),
      .clr     (wr_int_raw_s & apbif_wdata[i]),
      .q       (int_raw_s[i])
    );
  end

  // Interrupt output, registered from the enabled raw status
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(int_raw_s & int_en_r);
    end
  end

`ifdef LINE_BUFFER_REG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic [ERR_CNT_W-1:0] err_base_s;
  logic [ERR_CNT_W:0]   err_sum_s;
  logic [1:0]           err_inc_s;
  logic                 err_rd_clr_s;

  assign err_rd_clr_s = apbif_rd & hit_s & (offset_s == OFF_ERR_CNT);
  assign err_inc_s    = {1'b0, evt_overflow} + {1'b0, evt_underflow};

  // Next error count: a read restarts from zero, events still land, saturate
  always_comb begin
    err_base_s = err_rd_clr_s ? {ERR_CNT_W{1'b0}} : err_cnt_r;
    err_sum_s  = {1'b0, err_base_s} + {{(ERR_CNT_W-1){1'b0}}, err_inc_s};
  end

  // Error counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (err_sum_s[ERR_CNT_W]) begin
      err_cnt_r <= {ERR_CNT_W{1'b1}};
    end else begin
      err_cnt_r <= err_sum_s[ERR_CNT_W-1:0];
    end
  end
`else
  logic unused_rd;
  assign unused_rd = apbif_rd;
`endif

  // Read mux: combinational so data is valid in the same cycle as the strobe
  always_comb begin
    apbif_rdata = 32'h0000_0000;
    if (hit_s) begin
      case (offset_s)
        OFF_CTRL:     apbif_rdata = {{(32-CTRL_W){1'b0}}, ctrl_r};
        OFF_LINE_CFG: apbif_rdata = {{(32-LW_W){1'b0}}, line_width_r};
        OFF_STATUS:   apbif_rdata = {29'h0, sts_full, sts_empty, sts_busy};
        OFF_INT_RAW:  apbif_rdata = {{(32-INT_W){1'b0}}, int_raw_s};
        OFF_INT_EN:   apbif_rdata = {{(32-INT_W){1'b0}}, int_en_r};
        OFF_INT_STAT: apbif_rdata = {{(32-INT_W){1'b0}}, int_raw_s & int_en_r};
        OFF_VERSION:  apbif_rdata = VERSION;
`ifdef LINE_BUFFER_REG_ERR_CNT_EN
        OFF_ERR_CNT:  apbif_rdata = {{(32-ERR_CNT_W){1'b0}}, err_cnt_r};
`endif
        default:      apbif_rdata = 32'h0000_0000;
      endcase
    end else begin
      apbif_rdata = 32'h0000_0000;
    end
  end

  // Address byte-lane bits and write-data bits above every field are ignored
  logic unused_bits;
  assign unused_bits = &{1'b0, apbif_addr[1:0], apbif_wdata[31:LW_W]};

endmodule

// File: tb/tb_line_buffer_reg.sv
// Self-checking bench for line_buffer_reg: directed steps from the test plan
// followed by a randomized phase, all compared against a register-map model.
module tb_line_buffer_reg;

  logic        pclk, presetn;
  logic        apbif_wr, apbif_rd;
  logic [31:0] apbif_addr, apbif_wdata, apbif_rdata;
  logic        cfg_lb_en, cfg_bypass;
  logic [1:0]  cfg_pix_fmt;
  logic [12:0] cfg_line_width;
  logic        cmd_soft_rst, cmd_flush;
  logic        sts_busy, sts_empty, sts_full;
  logic        evt_frame_done, evt_overflow, evt_underflow;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [3:0]  m_ctrl;
  logic [12:0] m_lw;
  logic [2:0]  m_en, m_raw;
  logic        m_irq;
  logic [1:0]  m_cmd;
  logic [15:0] m_err;

  line_buffer_reg dut (
    .pclk(pclk), .presetn(presetn),
    .apbif_wr(apbif_wr), .apbif_rd(apbif_rd),
    .apbif_addr(apbif_addr), .apbif_wdata(apbif_wdata), .apbif_rdata(apbif_rdata),
    .cfg_lb_en(cfg_lb_en), .cfg_bypass(cfg_bypass), .cfg_pix_fmt(cfg_pix_fmt),
    .cfg_line_width(cfg_line_width),
    .cmd_soft_rst(cmd_soft_rst), .cmd_flush(cmd_flush),
    .sts_busy(sts_busy), .sts_empty(sts_empty), .sts_full(sts_full),
    .evt_frame_done(evt_frame_done), .evt_overflow(evt_overflow), .evt_underflow(evt_underflow),
    .irq(irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[31:8] == 24'h0) begin
      case (a[7:2])
        6'd0: r = {28'h0, m_ctrl};
        6'd1: r = {19'h0, m_lw};
        6'd3: r = {29'h0, sts_full, sts_empty, sts_busy};
        6'd4: r = {29'h0, m_raw};
        6'd5: r = {29'h0, m_en};
        6'd6: r = {29'h0, m_raw & m_en};
        6'd7: r = 32'h0001_0000;
`ifdef LINE_BUFFER_REG_ERR_CNT_EN
        6'd8: r = {16'h0, m_err};
`endif
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = 4'h0; m_lw = 13'd1920; m_en = 3'h0; m_raw = 3'h0;
    m_irq = 1'b0; m_cmd = 2'b00; m_err = 16'h0;
  endtask

  // One clock: predict from the inputs, clock, idle the strobes, compare outputs
  task automatic cycle();
    logic       hit, wr;
    logic [5:0] w;
    logic [3:0] n_ctrl;
    logic [12:0] n_lw;
    logic [2:0] n_en, n_raw;
    logic       n_irq;
    logic [1:0] n_cmd;
    int         e;
    hit    = (apbif_addr[31:8] == 24'h0);
    w      = apbif_addr[7:2];
    wr     = apbif_wr && hit;
    n_irq  = |(m_raw & m_en);
    n_cmd  = (wr && w == 6'd2) ? apbif_wdata[1:0] : 2'b00;
    n_ctrl = (wr && w == 6'd0) ? apbif_wdata[3:0] : m_ctrl;
    n_lw   = (wr && w == 6'd1) ? apbif_wdata[12:0] : m_lw;
    n_en   = (wr && w == 6'd5) ? apbif_wdata[2:0] : m_en;
    n_raw  = m_raw;
    if (wr && w == 6'd4) n_raw = n_raw & ~apbif_wdata[2:0];
    n_raw  = n_raw | {evt_underflow, evt_overflow, evt_frame_done};
    e = (apbif_rd && hit && w == 6'd8) ? 0 : int'(m_err);
    e = e + int'(evt_overflow) + int'(evt_underflow);
    if (e > 65535) e = 65535;
    @(posedge pclk);
    #1;
    m_ctrl = n_ctrl; m_lw = n_lw; m_en = n_en; m_raw = n_raw;
    m_irq = n_irq; m_cmd = n_cmd;
`ifdef LINE_BUFFER_REG_ERR_CNT_EN
    m_err = e[15:0];
`endif
    apbif_wr = 1'b0; apbif_rd = 1'b0;
    evt_frame_done = 1'b0; evt_overflow = 1'b0; evt_underflow = 1'b0;
    chk("cfg_ctrl", {28'h0, cfg_pix_fmt, cfg_bypass, cfg_lb_en}, {28'h0, m_ctrl});
    chk("cfg_lw", {19'h0, cfg_line_width}, {19'h0, m_lw});
    chk("cmd", {30'h0, cmd_flush, cmd_soft_rst}, {30'h0, m_cmd});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    apbif_addr = a; apbif_wdata = d; apbif_wr = 1'b1;
    cycle();
  endtask

  // Read with an independently known expected value, also cross-checked by the model
  task automatic rd(input logic [31:0] a, input logic [31:0] k, input string tag);
    apbif_addr = a; apbif_rd = 1'b1;
    #1;
    chk(tag, apbif_rdata, k);
    chk({tag, "_model"}, apbif_rdata, exp_read(a));
    cycle();
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    #1;
    model_reset();
    chk("rst_cmd", {30'h0, cmd_flush, cmd_soft_rst}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ctrl", {28'h0, cfg_pix_fmt, cfg_bypass, cfg_lb_en}, 32'h0);
    chk("rst_lw", {19'h0, cfg_line_width}, 32'h780);
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
  endtask

  initial begin
    presetn = 1'b1; apbif_wr = 1'b0; apbif_rd = 1'b0;
    apbif_addr = 32'h0; apbif_wdata = 32'h0;
    sts_busy = 1'b0; sts_empty = 1'b0; sts_full = 1'b0;
    evt_frame_done = 1'b0; evt_overflow = 1'b0; evt_underflow = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Reset values
    rd(32'h04, 32'h780, "rst_line_cfg");
    rd(32'h00, 32'h0, "rst_ctrl_rd");
    rd(32'h10, 32'h0, "rst_int_raw");
    rd(32'h14, 32'h0, "rst_int_en");

    // CTRL write and unmapped / non-hit writes
    wr(32'h00, 32'h0000_000F);
    chk("ctrl_cfg", {28'h0, cfg_pix_fmt, cfg_bypass, cfg_lb_en}, 32'hF);
    rd(32'h00, 32'hF, "ctrl_rd");
    wr(32'h40, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0, "unmapped_rd");
    wr(32'h100, 32'h0);
    rd(32'h00, 32'hF, "miss_wr_ignored");
    rd(32'h100, 32'h0, "miss_rd");
    wr(32'h03, 32'hFFFF_FFF6);
    rd(32'h01, 32'h6, "ctrl_lowbits_ignored");

    // Command pulses
    wr(32'h08, 32'h3);
    chk("cmd_pulse", {30'h0, cmd_flush, cmd_soft_rst}, 32'h3);
    rd(32'h08, 32'h0, "cmd_rd");
    chk("cmd_end", {30'h0, cmd_flush, cmd_soft_rst}, 32'h0);
    wr(32'h08, 32'h1);
    chk("cmd_b2b_1", {30'h0, cmd_flush, cmd_soft_rst}, 32'h1);
    wr(32'h08, 32'h2);
    chk("cmd_b2b_2", {30'h0, cmd_flush, cmd_soft_rst}, 32'h2);
    wr(32'h08, 32'h0);
    chk("cmd_zero", {30'h0, cmd_flush, cmd_soft_rst}, 32'h0);

    // Overflow interrupt with enable, set-wins, then clear
    wr(32'h14, 32'h2);
    evt_overflow = 1'b1;
    cycle();
    chk("irq_lat1", {31'h0, irq}, 32'h0);
    rd(32'h10, 32'h2, "raw_ovf");
    chk("irq_lat2", {31'h0, irq}, 32'h1);
    rd(32'h18, 32'h2, "stat_ovf");
    evt_overflow = 1'b1;
    wr(32'h10, 32'h2);
    rd(32'h10, 32'h2, "set_wins");
    wr(32'h10, 32'h2);
    chk("irq_clr1", {31'h0, irq}, 32'h1);
    cycle();
    chk("irq_clr2", {31'h0, irq}, 32'h0);
    rd(32'h10, 32'h0, "raw_cleared");

    // Frame-done captured while disabled
    wr(32'h14, 32'h0);
    evt_frame_done = 1'b1;
    cycle();
    rd(32'h10, 32'h1, "raw_fd");
    rd(32'h18, 32'h0, "stat_masked");
    chk("irq_masked", {31'h0, irq}, 32'h0);

    // LINE_CFG, VERSION, STATUS, read-only writes
    wr(32'h04, 32'h1234_5ABC);
    rd(32'h04, 32'h1ABC, "line_cfg_rd");
    rd(32'h1C, 32'h0001_0000, "version");
    sts_busy = 1'b1; sts_empty = 1'b0; sts_full = 1'b1;
    rd(32'h0C, 32'h5, "status");
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h1C, 32'h0);
    rd(32'h0C, 32'h5, "status_ro");
    rd(32'h1C, 32'h0001_0000, "version_ro");
`ifndef LINE_BUFFER_REG_ERR_CNT_EN
    rd(32'h20, 32'h0, "errcnt_absent");
`endif

    // Reset while a command pulse is high
    wr(32'h08, 32'h3);
    chk("pulse_before_rst", {30'h0, cmd_flush, cmd_soft_rst}, 32'h3);
    do_reset();
    rd(32'h04, 32'h780, "rst2_line_cfg");
    rd(32'h10, 32'h0, "rst2_int_raw");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {24'h0, 6'($urandom_range(0, 10)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom_range(1, 255));
      apbif_addr  = a;
      apbif_wdata = $urandom;
      apbif_wr    = ($urandom_range(0, 2) == 0);
      apbif_rd    = !apbif_wr && ($urandom_range(0, 1) == 0);
      evt_frame_done = ($urandom_range(0, 3) == 0);
      evt_overflow   = ($urandom_range(0, 3) == 0);
      evt_underflow  = ($urandom_range(0, 3) == 0);
      sts_busy = 1'($urandom); sts_empty = 1'($urandom); sts_full = 1'($urandom);
      #1;
      chk("rnd_rdata", apbif_rdata, exp_read(a));
      cycle();
    end

`ifdef LINE_BUFFER_REG_ERR_CNT_EN
    // Error counter: read-clear, dual increment, saturation
    apbif_addr = 32'h20; apbif_rd = 1'b1;
    #1;
    chk("err_pre", apbif_rdata, exp_read(32'h20));
    cycle();
    for (int i = 0; i < 3; i++) begin
      evt_overflow = 1'b1;
      cycle();
    end
    rd(32'h20, 32'h3, "err_three");
    rd(32'h20, 32'h0, "err_cleared");
    evt_overflow = 1'b1; evt_underflow = 1'b1;
    rd(32'h20, 32'h0, "err_clr_with_evt");
    rd(32'h20, 32'h2, "err_dual_inc");
    for (int i = 0; i < 32768; i++) begin
      evt_overflow = 1'b1; evt_underflow = 1'b1;
      cycle();
    end
    evt_overflow = 1'b1;
    cycle();
    rd(32'h20, 32'hFFFF, "err_saturate");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_reg.md
Name: line_buffer_reg

Overview:
Register file that sits directly downstream of the line-buffer APB translation block. It consumes apbif_wr/apbif_rd/apbif_addr/apbif_wdata and returns apbif_rdata.
- Holds line-buffer configuration registers.
- Generates self-clearing command pulses.
- Captures hardware events into W1C interrupt status and drives a masked, registered irq.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base of the 256-byte register window
LW_W, 13, width of line_width field
LW_RST, 13'd1920, reset value of line_width
VERSION, 32'h0001_0000, value of VERSION register

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
apbif_wr  in  1  write strobe (access phase)
apbif_rd  in  1  read strobe (setup phase)
apbif_addr  in  32  byte address
apbif_wdata  in  32  write data
apbif_rdata  out  32  read data, combinational from apbif_addr
cfg_lb_en  out  1  CTRL[0]
cfg_bypass  out  1  CTRL[1]
cfg_pix_fmt  out  2  CTRL[3:2]
cfg_line_width  out  LW_W  LINE_CFG[LW_W-1:0]
cmd_soft_rst  out  1  one-cycle pulse
cmd_flush  out  1  one-cycle pulse
sts_busy, sts_empty, sts_full  in  1 each  core status, pclk domain
evt_frame_done, evt_overflow, evt_underflow  in  1 each  single-cycle event pulses, pclk domain
irq  out  1  registered interrupt

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous and active-low.
- Decode: hit when apbif_addr[31:8] == BASE_ADDR[31:8]. Offset is apbif_addr[7:2]; apbif_addr[1:0] is ignored.
- Register map:
  - 0x00 CTRL: RW bits [3:0], reset 0.
  - 0x04 LINE_CFG: RW [LW_W-1:0], reset LW_RST.
  - 0x08 CMD: write-only; bit0 soft_rst, bit1 flush; reads 0.
  - 0x0C STATUS: RO {busy, empty, full} in bits [0], [1], [2].
  - 0x10 INT_RAW: W1C bits [2:0] = {underflow, overflow, frame_done}.
  - 0x14 INT_EN: RW [2:0], reset 0.
  - 0x18 INT_STAT: RO, INT_RAW & INT_EN.
  - 0x1C VERSION: RO.
- Unused bits read 0. Unmapped or non-hit reads return 0; writes there are ignored with no side effects.
- Writes: a register updates on the pclk edge where apbif_wr=1 and the address hits. The new value appears on apbif_rdata and cfg_* from the next cycle.
- Reads: apbif_rdata is purely combinational from apbif_addr and current register state. It must be valid in the cycle apbif_rd=1, because the upstream stage latches it on that edge.
- CMD: a write with bit=1 drives the corresponding cmd_* high for exactly the following cycle. Writing 0 does nothing. Back-to-back writes give back-to-back pulses.
- INT_RAW:
  - Bit is set on an event pulse and is sticky.
  - Cleared by a write of 1 to that bit.
  - An event in the same cycle as its W1C leaves the bit set (set wins).
  - Events are captured regardless of INT_EN.
- irq: registered, irq <= |(INT_RAW & INT_EN). Asserts 2 cycles after an event pulse (1 cycle to set RAW, 1 to register irq). Deasserts 2 cycles after the clearing write edge.
- Reset: all RW and W1C registers take their reset values; cmd_* = 0, irq = 0. Reset asserted mid-pulse terminates the pulse immediately.
- No wait states; no error response.

Optional Feature:
LINE_BUFFER_REG_ERR_CNT_EN
- Defined: adds 0x20 ERR_CNT, RO, 16-bit, reset 0.
  - Increments on evt_overflow or evt_underflow; both in one cycle add 2. Saturates at 0xFFFF.
  - Cleared on read: apbif_rd=1 with offset 0x20.
  - Read-clear in the same cycle as an event: counter becomes the event increment (1 or 2).
  - apbif_rdata returns the pre-clear value.
- Not defined: offset 0x20 is unmapped (reads 0); no counter flops exist.

Decomposition:
- Package line_buffer_reg_pkg holds:
  - register offset constants;
  - field bit positions and widths;
  - CTRL/INT_EN reset constants;
  - INT bit index constants (FRAME_DONE=0, OVERFLOW=1, UNDERFLOW=2).
- One sub-module, line_buffer_reg_w1c: single sticky interrupt bit with set/W1C and set-wins priority, instantiated 3x.

Test Plan:
- Reset: presetn low then high -> read 0x04 returns 0x780, reads of 0x00/0x10/0x14 return 0, irq=0, cmd_*=0.
- Write 0x00=0xF then read -> cfg_lb_en=1, cfg_bypass=1, cfg_pix_fmt=3 next cycle, readback 0xF. Write 0x40 -> ignored, reads 0.
- Write 0x08=0x3 -> cmd_soft_rst and cmd_flush high for exactly one cycle. Read 0x08 returns 0.
- INT_EN=0x2, pulse evt_overflow -> INT_RAW=0x2, irq high 2 cycles later. Write 0x10=0x2 with a simultaneous evt_overflow -> bit stays set. Clear again with no event -> irq low 2 cycles after write.
- Pulse evt_frame_done with INT_EN=0 -> INT_RAW=0x1, INT_STAT=0, irq stays 0.
- ERR_CNT_EN build: 3 overflow pulses -> read 0x20 returns 3, a second read returns 0. Force 0xFFFF plus one event -> stays 0xFFFF.
